pipeline_hazard_ctrl: RTL

//  Parametrised pipeline hazard controller that replaces the single-cycle stall/flush OR-gate.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_mc_timer.sv | 80 ++++++++
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e   : multi-cycle timer states (IDLE, MC_BUSY)
//   hz_ctrl_t    : stall/flush enable bundle driven to the F/D/E/M pipeline registers
//   PERF_*_IDX   : counter offsets past the N_SRC single-cycle request counters
//   perf_sel_w() : width of the perf counter select for a given N_SRC
package hazard_pkg;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MC_BUSY = 1'b1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } hz_ctrl_t;

    localparam int unsigned PERF_BR_IDX = 0;
    localparam int unsigned PERF_MC_IDX = 1;

    function automatic int unsigned perf_sel_w(input int unsigned n_src);
        return $clog2(n_src + 2);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard request / pipeline control bundle.
//   master : pipeline side; drives haz_req, branch_taken, mc_start, mc_cycles, perf_sel
//   slave  : hazard controller; drives StallF/D/E, FlushD/E/M, mc_busy, mc_done,
//            stall_timeout, perf_cnt
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned N_SRC  = 3,
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
);
    import hazard_pkg::*;

    localparam int unsigned SEL_W = perf_sel_w(N_SRC);

    logic [N_SRC-1:0]  haz_req;
    logic              branch_taken;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_cycles;
    logic [SEL_W-1:0]  perf_sel;

    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              FlushD;
    logic              FlushE;
    logic              FlushM;
    logic              mc_busy;
    logic              mc_done;
    logic              stall_timeout;
    logic [PERF_W-1:0] perf_cnt;

    modport master (
        output haz_req, branch_taken, mc_start, mc_cycles, perf_sel,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
               mc_busy, mc_done, stall_timeout, perf_cnt
    );

    modport slave (
        input  haz_req, branch_taken, mc_start, mc_cycles, perf_sel,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
               mc_busy, mc_done, stall_timeout, perf_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_mc_timer.sv
// Multi-cycle Execute stall timer: IDLE/MC_BUSY FSM, down-counter, mc_done pulse.
//   clk, reset : clock, synchronous active-high reset
//   start      : multi-cycle op enters E (ignored while busy)
//   cycles     : total stall cycles for the op, sampled with start
//   kill       : branch redirect or reset; squashes the op without mc_done
//   busy_now   : stall this cycle (start cycle with cycles>0, or MC_BUSY)
//   mc_busy    : FSM in MC_BUSY
//   mc_done    : registered pulse the cycle after the last stall cycle
module hazard_mc_timer
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             kill,
    output logic             busy_now,
    output logic             mc_busy,
    output logic             mc_done
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // State, counter and done registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Counter holds remaining MC_BUSY cycles minus one; the start cycle is
    // already one stall, so an N-cycle op loads N-2.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        busy_now = 1'b0;
        if (kill) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_now = (cycles != '0);
                        if (cycles > CNT_W'(1)) begin
                            state_d = S_MC_BUSY;
                            cnt_d   = cycles - CNT_W'(2);
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_MC_BUSY: begin
                    busy_now = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign mc_busy = (state_q == S_MC_BUSY);
    assign mc_done = done_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: merges single-cycle stall
// requests, branch-redirect flush and the multi-cycle Execute stall into the
// F/D/E/M stall/flush enables, with a sticky stall watchdog.
// Optional build macro HAZARD_PERF_EN adds saturating per-cause counters read
// through perf_sel/perf_cnt; without it perf_cnt is 0 and perf_sel is unused.
//   clk, reset : clock, synchronous active-high reset (forces all outputs to 0)
//   bus        : pipeline_hazard_ctrl_if.slave (requests in, enables/status out)
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned N_SRC     = 3,
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned MAX_STALL = 64,
    parameter int unsigned PERF_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);
    localparam int unsigned N_CNT = N_SRC + 2;
    localparam int unsigned SEL_W = perf_sel_w(N_SRC);

    hz_ctrl_t         ctl;
    logic             haz_eff;
    logic             busy_now;
    logic             mc_busy_w;
    logic             mc_done_w;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    hazard_mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (bus.mc_start),
        .cycles   (bus.mc_cycles),
        .kill     (bus.branch_taken | reset),
        .busy_now (busy_now),
        .mc_busy  (mc_busy_w),
        .mc_done  (mc_done_w)
    );

    // Priority: reset > branch_taken > multi-cycle > haz_req.
    // busy_now is already cleared by kill, so it never fires with reset/branch.
    always_comb begin
        ctl     = '0;
        haz_eff = ~reset & ~bus.branch_taken & ~busy_now & ~mc_busy_w & ~bus.mc_start;
        if (!reset && bus.branch_taken) begin
            ctl.flush_d = 1'b1;
            ctl.flush_e = 1'b1;
        end else if (busy_now) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.stall_e = 1'b1;
            ctl.flush_m = 1'b1;
        end else if (haz_eff) begin
            ctl.stall_f = |bus.haz_req;
            ctl.stall_d = |bus.haz_req;
            ctl.flush_e = |bus.haz_req;
        end
    end

    // Watchdog: count consecutive StallF cycles, saturate, latch timeout
    always_comb begin
        run_d = '0;
        if (ctl.stall_f) begin
            run_d = (run_q == RUN_W'(MAX_STALL)) ? run_q : run_q + RUN_W'(1);
        end
        timeout_d = timeout_q | (run_d == RUN_W'(MAX_STALL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.StallF        = ctl.stall_f;
    assign bus.StallD        = ctl.stall_d;
    assign bus.StallE        = ctl.stall_e;
    assign bus.FlushD        = ctl.flush_d;
    assign bus.FlushE        = ctl.flush_e;
    assign bus.FlushM        = ctl.flush_m;
    assign bus.mc_busy       = mc_busy_w & ~reset;
    assign bus.mc_done       = mc_done_w & ~reset;
    assign bus.stall_timeout = timeout_q & ~reset;

`ifdef HAZARD_PERF_EN
    logic [N_CNT-1:0]  inc;
    logic [PERF_W-1:0] cnt_q [N_CNT];
    logic [PERF_W-1:0] perf_q, perf_d;

    // Per-cause increment strobes
    for (genvar g = 0; g < N_SRC; g++) begin : g_haz_inc
        assign inc[g] = haz_eff & bus.haz_req[g];
    end
    assign inc[N_SRC + PERF_BR_IDX] = ~reset & bus.branch_taken;
    assign inc[N_SRC + PERF_MC_IDX] = busy_now;

    // Saturating counters, stick at all-ones
    for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q[g] <= '0;
            end else if (inc[g] && (cnt_q[g] != '1)) begin
                cnt_q[g] <= cnt_q[g] + PERF_W'(1);
            end
        end
    end

    // Registered read-out; out-of-range selects return 0
    always_comb begin
        perf_d = '0;
        if (32'(bus.perf_sel) < 32'(N_CNT)) begin
            perf_d = cnt_q[bus.perf_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.perf_cnt = reset ? '0 : perf_q;
`else
    logic perf_sel_unused;
    assign perf_sel_unused = ^{bus.perf_sel, haz_eff, SEL_W'(0)};
    assign bus.perf_cnt    = '0;
`endif

endmodule
